// File: rtl/pc_transfer_unit_pkg.sv
// Shared types, default sizing and FSM state encodings for the PC transfer unit.
// No logic, so no latency or backpressure of its own.
package pc_transfer_unit_pkg;

    typedef logic [7:0] byte_t;
    typedef logic       control_t;

    localparam int PC_BYTES_DEF = 2;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_DONE    = 2'd2
    } load_state_t;

    typedef enum logic {
        SV_IDLE = 1'b0,
        SV_EMIT = 1'b1
    } save_state_t;

endpackage

// File: rtl/pc_byte_serializer.sv
// PC-wide byte shift register with byte index; MSB_IN=1 shifts bytes in at the bottom,
// MSB_IN=0 parallel-loads and shifts out from the bottom. One cycle per byte, stalls when i_shift is low.
module pc_byte_serializer
    import pc_transfer_unit_pkg::*;
#(
    parameter int PC_BYTES = PC_BYTES_DEF,
    parameter bit MSB_IN   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  control_t              i_clr,
    input  control_t              i_load,
    input  control_t              i_shift,
    input  logic [8*PC_BYTES-1:0] i_par_dat,
    input  byte_t                 i_byte_dat,
    output logic [8*PC_BYTES-1:0] o_par_dat,
    output logic                  o_last
);

    localparam int W  = 8 * PC_BYTES;
    localparam int IW = $clog2(PC_BYTES);

    logic [W-1:0]  r_sh;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  w_sh_nxt;

    assign w_sh_nxt  = MSB_IN ? {r_sh[W-9:0], i_byte_dat} : {i_byte_dat, r_sh[W-1:8]};
    assign o_par_dat = r_sh;
    assign o_last    = (r_idx == IW'(PC_BYTES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sh  <= '0;
            r_idx <= '0;
        end else begin
            if (i_load) begin
                r_sh <= i_par_dat;
            end else if (i_shift) begin
                r_sh <= w_sh_nxt;
            end
            if (i_clr || i_load) begin
                r_idx <= '0;
            end else if (i_shift) begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_transfer_unit.sv
// Byte-serial PC load/save engines plus an ALU-result LIFO; load done PC_BYTES+1 cycles after start
// with no-gap bytes, save stalls on save_ready low, cache results visible the cycle after the operation.
module pc_transfer_unit
    import pc_transfer_unit_pkg::*;
#(
    parameter int PC_BYTES    = PC_BYTES_DEF,
    parameter int CACHE_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  control_t              load_start,
    input  control_t              mem_valid,
    input  byte_t                 mem_out,
    output logic [8*PC_BYTES-1:0] load_out,
    output logic                  load_busy,
    output logic                  load_done,
    input  control_t              save_start,
    input  logic [8*PC_BYTES-1:0] pc,
    output byte_t                 save_out,
    output logic                  save_valid,
    input  control_t              save_ready,
    output logic                  save_done,
    input  byte_t                 alu_out,
    input  control_t              cache_push,
    input  control_t              cache_pop,
    output byte_t                 cache_out,
    output logic                  cache_empty,
    output logic                  cache_full,
    output logic                  cache_overflow
);

    localparam int W  = 8 * PC_BYTES;
    localparam int CW = $clog2(CACHE_DEPTH + 1);
    localparam int IW = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;

    load_state_t r_ld_state, w_ld_state_nxt;
    save_state_t r_sv_state, w_sv_state_nxt;
    logic         w_ld_clr, w_ld_shift, w_ld_last;
    logic         w_sv_load, w_sv_shift, w_sv_last;
    logic [W-1:0] w_ld_par, w_sv_par;
    logic [W-1:0] r_load_out;
    logic         w_unused;

    pc_byte_serializer #(.PC_BYTES(PC_BYTES), .MSB_IN(1'b1)) u_load_ser (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clr      (w_ld_clr),
        .i_load     (1'b0),
        .i_shift    (w_ld_shift),
        .i_par_dat  ({W{1'b0}}),
        .i_byte_dat (mem_out),
        .o_par_dat  (w_ld_par),
        .o_last     (w_ld_last)
    );

    // Save shifts right so the low byte goes first; a stack pop then yields MSB first.
    pc_byte_serializer #(.PC_BYTES(PC_BYTES), .MSB_IN(1'b0)) u_save_ser (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clr      (1'b0),
        .i_load     (w_sv_load),
        .i_shift    (w_sv_shift),
        .i_par_dat  (pc),
        .i_byte_dat (8'h00),
        .o_par_dat  (w_sv_par),
        .o_last     (w_sv_last)
    );

    assign w_unused = ^{w_ld_par[W-1:W-8], w_sv_par[W-1:8]};

    always_comb begin
        w_ld_state_nxt = r_ld_state;
        w_ld_clr       = 1'b0;
        w_ld_shift     = 1'b0;
        case (r_ld_state)
            LD_IDLE: begin
                if (load_start) begin
                    w_ld_clr       = 1'b1;
                    w_ld_state_nxt = LD_COLLECT;
                end
            end
            LD_COLLECT: begin
                if (mem_valid) begin
                    w_ld_shift = 1'b1;
                    if (w_ld_last) w_ld_state_nxt = LD_DONE;
                end
            end
            LD_DONE: w_ld_state_nxt = LD_IDLE;
            default: w_ld_state_nxt = LD_IDLE;
        endcase
    end

    always_comb begin
        w_sv_state_nxt = r_sv_state;
        w_sv_load      = 1'b0;
        w_sv_shift     = 1'b0;
        case (r_sv_state)
            SV_IDLE: begin
                if (save_start) begin
                    w_sv_load      = 1'b1;
                    w_sv_state_nxt = SV_EMIT;
                end
            end
            SV_EMIT: begin
                if (save_ready) begin
                    w_sv_shift = 1'b1;
                    if (w_sv_last) w_sv_state_nxt = SV_IDLE;
                end
            end
            default: w_sv_state_nxt = SV_IDLE;
        endcase
    end

    // The assembled word is captured on the last byte so it is already visible while load_done is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ld_state <= LD_IDLE;
            r_sv_state <= SV_IDLE;
            r_load_out <= '0;
        end else begin
            r_ld_state <= w_ld_state_nxt;
            r_sv_state <= w_sv_state_nxt;
            if (w_ld_shift && w_ld_last) r_load_out <= {w_ld_par[W-9:0], mem_out};
        end
    end

    assign load_out   = r_load_out;
    assign load_busy  = (r_ld_state == LD_COLLECT);
    assign load_done  = (r_ld_state == LD_DONE);
    assign save_valid = (r_sv_state == SV_EMIT);
    assign save_done  = save_valid && save_ready && w_sv_last;
    assign save_out   = save_valid ? w_sv_par[7:0] : 8'h00;

    byte_t         r_stack [CACHE_DEPTH];
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_overflow;
    logic          w_empty, w_full, w_wr_en;
    logic [IW-1:0] w_wr_idx, w_top_idx;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(CACHE_DEPTH));
    assign w_top_idx = IW'(r_count - CW'(1));

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_idx    = w_top_idx;
        w_count_nxt = r_count;
        if (cache_push && cache_pop) begin
            w_wr_en = 1'b1;
            if (w_empty) begin
                w_wr_idx    = '0;
                w_count_nxt = CW'(1);
            end
        end else if (cache_push) begin
            if (!w_full) begin
                w_wr_en     = 1'b1;
                w_wr_idx    = IW'(r_count);
                w_count_nxt = r_count + CW'(1);
            end
        end else if (cache_pop) begin
            if (!w_empty) w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (cache_push && !cache_pop && w_full) r_overflow <= 1'b1;
        end
    end

    // Entries above the count are never read, so the array needs no reset.
    always_ff @(posedge clock) begin
        if (w_wr_en) r_stack[w_wr_idx] <= alu_out;
    end

    assign cache_out      = w_empty ? 8'h00 : r_stack[w_top_idx];
    assign cache_empty    = w_empty;
    assign cache_full     = w_full;
    assign cache_overflow = r_overflow;

endmodule

// File: tb/tb_pc_transfer_unit.sv
// Directed bench for pc_transfer_unit: a 2-byte instance for the main cases and a
// 3-byte instance for the wider-PC regression, both driven from shared stimulus.
module tb_pc_transfer_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_start = 1'b0, mem_valid = 1'b0;
    logic [7:0]  mem_out = 8'h00;
    logic        save_start = 1'b0, save_ready = 1'b0;
    logic [15:0] pc2 = 16'h0;
    logic [23:0] pc3 = 24'h0;
    logic [7:0]  alu_out = 8'h00;
    logic        cache_push = 1'b0, cache_pop = 1'b0;

    logic [15:0] load_out2;
    logic        load_busy2, load_done2, save_valid2, save_done2;
    logic [7:0]  save_out2, cache_out2;
    logic        cache_empty2, cache_full2, cache_overflow2;

    logic [23:0] load_out3;
    logic        load_busy3, load_done3, save_valid3, save_done3;
    logic [7:0]  save_out3, cache_out3;
    logic        cache_empty3, cache_full3, cache_overflow3;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    pc_transfer_unit #(.PC_BYTES(2), .CACHE_DEPTH(4)) u_dut2 (
        .clock(clock), .reset_n(reset_n),
        .load_start(load_start), .mem_valid(mem_valid), .mem_out(mem_out),
        .load_out(load_out2), .load_busy(load_busy2), .load_done(load_done2),
        .save_start(save_start), .pc(pc2), .save_out(save_out2),
        .save_valid(save_valid2), .save_ready(save_ready), .save_done(save_done2),
        .alu_out(alu_out), .cache_push(cache_push), .cache_pop(cache_pop),
        .cache_out(cache_out2), .cache_empty(cache_empty2), .cache_full(cache_full2),
        .cache_overflow(cache_overflow2)
    );

    pc_transfer_unit #(.PC_BYTES(3), .CACHE_DEPTH(4)) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .load_start(load_start), .mem_valid(mem_valid), .mem_out(mem_out),
        .load_out(load_out3), .load_busy(load_busy3), .load_done(load_done3),
        .save_start(save_start), .pc(pc3), .save_out(save_out3),
        .save_valid(save_valid3), .save_ready(save_ready), .save_done(save_done3),
        .alu_out(alu_out), .cache_push(cache_push), .cache_pop(cache_pop),
        .cache_out(cache_out3), .cache_empty(cache_empty3), .cache_full(cache_full3),
        .cache_overflow(cache_overflow3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int n_ld_done;
    int n_sv_done;

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_load_out",   load_out2, 0);
        check("rst_load_busy",  load_busy2, 0);
        check("rst_load_done",  load_done2, 0);
        check("rst_save_valid", save_valid2, 0);
        check("rst_save_out",   save_out2, 0);
        check("rst_cache_out",  cache_out2, 0);
        check("rst_empty",      cache_empty2, 1);
        check("rst_full",       cache_full2, 0);
        check("rst_ovf",        cache_overflow2, 0);
        reset_n = 1'b1;
        tick();

        // Load 0x12, 0x34; the byte in the start cycle must be ignored
        load_start = 1'b1; mem_valid = 1'b1; mem_out = 8'hFF;
        tick();
        load_start = 1'b0; mem_out = 8'h12;
        check("ld1_busy_c1", load_busy2, 1);
        tick();
        mem_out = 8'h34;
        check("ld1_done_c2", load_done2, 0);
        tick();
        mem_valid = 1'b0;
        check("ld1_done_c3", load_done2, 1);
        check("ld1_out_c3",  load_out2, 32'h1234);
        check("ld1_busy_c3", load_busy2, 0);
        tick();
        check("ld1_done_c4", load_done2, 0);
        check("ld1_hold_c4", load_out2, 32'h1234);

        // Load with a two-cycle gap and a stray load_start mid-load
        load_start = 1'b1;
        tick();
        load_start = 1'b0; mem_valid = 1'b1; mem_out = 8'hAB;
        tick();
        mem_valid = 1'b0; load_start = 1'b1;
        check("ld2_busy_gap", load_busy2, 1);
        tick();
        load_start = 1'b0;
        tick();
        mem_valid = 1'b1; mem_out = 8'hCD;
        check("ld2_done_c4", load_done2, 0);
        tick();
        mem_valid = 1'b0;
        check("ld2_done_c5", load_done2, 1);
        check("ld2_out_c5",  load_out2, 32'hABCD);
        tick();
        check("ld2_done_c6", load_done2, 0);
        check("ld2_busy_c6", load_busy2, 0);

        // Save 0xBEEF with backpressure, pc changed mid-save
        pc2 = 16'hBEEF; save_start = 1'b1; save_ready = 1'b0;
        #1;
        check("sv1_valid_c0", save_valid2, 0);
        check("sv1_out_c0",   save_out2, 0);
        tick();
        save_start = 1'b0; pc2 = 16'h0000;
        #1;
        check("sv1_valid_c1", save_valid2, 1);
        check("sv1_out_c1",   save_out2, 32'hEF);
        check("sv1_done_c1",  save_done2, 0);
        tick();
        save_ready = 1'b1;
        #1;
        check("sv1_out_c2",  save_out2, 32'hEF);
        check("sv1_done_c2", save_done2, 0);
        tick();
        save_start = 1'b1; pc2 = 16'h1111;
        #1;
        check("sv1_out_c3",  save_out2, 32'hBE);
        check("sv1_done_c3", save_done2, 1);
        tick();
        pc2 = 16'h1234; save_ready = 1'b0;
        #1;
        check("sv1_valid_c4", save_valid2, 0);
        check("sv1_out_c4",   save_out2, 0);
        tick();
        save_start = 1'b0; pc2 = 16'h0000; save_ready = 1'b1;
        #1;
        check("sv2_out_c5",  save_out2, 32'h34);
        check("sv2_done_c5", save_done2, 0);
        tick();
        #1;
        check("sv2_out_c6",  save_out2, 32'h12);
        check("sv2_done_c6", save_done2, 1);
        tick();
        save_ready = 1'b0;
        check("sv2_idle_c7", save_valid2, 0);

        // Cache stack
        cache_push = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            alu_out = 8'(i);
            tick();
            check("ca_push_top", cache_out2, i);
        end
        check("ca_full", cache_full2, 1);
        check("ca_empty_n", cache_empty2, 0);
        check("ca_ovf_pre", cache_overflow2, 0);
        alu_out = 8'd5;
        tick();
        check("ca_ovf", cache_overflow2, 1);
        check("ca_ovf_top", cache_out2, 4);
        cache_pop = 1'b1; alu_out = 8'd9;
        tick();
        check("ca_repl_top", cache_out2, 9);
        check("ca_repl_full", cache_full2, 1);
        cache_push = 1'b0;
        tick();
        check("ca_pop1_top", cache_out2, 3);
        check("ca_pop1_full", cache_full2, 0);
        tick();
        tick();
        check("ca_pop3_top", cache_out2, 1);
        tick();
        check("ca_pop4_empty", cache_empty2, 1);
        check("ca_pop4_out", cache_out2, 0);
        check("ca_ovf_sticky", cache_overflow2, 1);
        tick();
        check("ca_pop_empty", cache_empty2, 1);
        cache_push = 1'b1; alu_out = 8'd7;
        tick();
        check("ca_pp_empty_top", cache_out2, 7);
        check("ca_pp_empty_n", cache_empty2, 0);
        cache_push = 1'b0;
        tick();
        cache_pop = 1'b0;
        check("ca_final_empty", cache_empty2, 1);

        // Reset while load collects and save emits
        load_start = 1'b1; save_start = 1'b1; pc2 = 16'hCAFE; save_ready = 1'b0;
        cache_push = 1'b1; alu_out = 8'h77;
        tick();
        load_start = 1'b0; save_start = 1'b0; cache_push = 1'b0;
        mem_valid = 1'b1; mem_out = 8'h55;
        check("rm_busy", load_busy2, 1);
        check("rm_valid", save_valid2, 1);
        check("rm_cache", cache_out2, 32'h77);
        tick();
        mem_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rm_load_out", load_out2, 0);
        check("rm_busy_rst", load_busy2, 0);
        check("rm_valid_rst", save_valid2, 0);
        check("rm_save_out", save_out2, 0);
        check("rm_cache_out", cache_out2, 0);
        check("rm_empty", cache_empty2, 1);
        check("rm_ovf", cache_overflow2, 0);
        tick();
        tick();
        reset_n = 1'b1;
        mem_valid = 1'b1; mem_out = 8'h66; save_ready = 1'b1;
        n_ld_done = 0;
        n_sv_done = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (load_done2 || load_done3) n_ld_done++;
            if (save_done2 || save_done3) n_sv_done++;
            tick();
        end
        check("rm_no_load_done", n_ld_done, 0);
        check("rm_no_save_done", n_sv_done, 0);
        check("rm_load_out_after", load_out2, 0);
        mem_valid = 1'b0; save_ready = 1'b0;
        tick();

        // Three-byte PC: concurrent load and save
        load_start = 1'b1; save_start = 1'b1; pc3 = 24'h0A0B0C; save_ready = 1'b1;
        tick();
        load_start = 1'b0; save_start = 1'b0; pc3 = 24'h0;
        mem_valid = 1'b1; mem_out = 8'h01;
        #1;
        check("p3_sv_out_c1", save_out3, 32'h0C);
        check("p3_sv_done_c1", save_done3, 0);
        tick();
        mem_out = 8'h02;
        #1;
        check("p3_sv_out_c2", save_out3, 32'h0B);
        check("p3_ld_done_c2", load_done3, 0);
        tick();
        mem_out = 8'h03;
        #1;
        check("p3_sv_out_c3", save_out3, 32'h0A);
        check("p3_sv_done_c3", save_done3, 1);
        tick();
        mem_valid = 1'b0; save_ready = 1'b0;
        check("p3_ld_done_c4", load_done3, 1);
        check("p3_ld_out_c4", load_out3, 32'h010203);
        check("p3_sv_idle_c4", save_valid3, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
